// File: rtl/sum_of_squares_pkg.sv
// sum_of_squares_pkg: shared widths and FSM state encoding for the sum-of-squares block.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package sum_of_squares_pkg;

  localparam int SOS_IN_W  = 12;
  localparam int SOS_FRAC  = 4;
  localparam int SOS_OUT_W = 12;
  localparam int SOS_ACC_W = 2*SOS_IN_W - SOS_FRAC + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_X = 3'd1,
    SQ_Y = 3'd2,
    SQ_Z = 3'd3,
    SAT  = 3'd4,
    OUT  = 3'd5
  } sos_state_t;

endpackage

`default_nettype wire

// File: rtl/sum_of_squares_fx_square.sv
// fx_square: combinational |v|^2 >> FRAC; rounds half-up when SUM_OF_SQUARES_ROUND_EN is defined.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module fx_square
  import sum_of_squares_pkg::*;
#(
  parameter int IN_W = SOS_IN_W,
  parameter int FRAC = SOS_FRAC
) (
  input  logic [IN_W-1:0]        i_v,
  output logic [2*IN_W-FRAC-1:0] o_sq
);

  localparam int PROD_W = 2*IN_W;

  logic [IN_W-1:0]   w_mag;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_prod_adj;

  // The most negative input negates to itself, which read unsigned is exactly 2^(IN_W-1).
  assign w_mag  = i_v[IN_W-1] ? (~i_v + IN_W'(1)) : i_v;
  assign w_prod = PROD_W'(w_mag) * PROD_W'(w_mag);

`ifdef SUM_OF_SQUARES_ROUND_EN
  localparam logic [PROD_W-1:0] c_half = PROD_W'(1) << (FRAC-1);
  assign w_prod_adj = w_prod + c_half;
`else
  assign w_prod_adj = w_prod;
`endif

  assign o_sq = w_prod_adj[PROD_W-1:FRAC];

endmodule

`default_nettype wire

// File: rtl/sum_of_squares.sv
// sum_of_squares: x^2+y^2+z^2 over one shared squarer in three cycles, saturated to OUT_W bits.
// Optional macro SUM_OF_SQUARES_ROUND_EN selects round-half-up per term. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module sum_of_squares
  import sum_of_squares_pkg::*;
#(
  parameter int IN_W  = SOS_IN_W,
  parameter int FRAC  = SOS_FRAC,
  parameter int OUT_W = SOS_OUT_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  input  logic [IN_W-1:0]  z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sq,
  output logic             out_sat
);

  localparam int ACC_W = 2*IN_W - FRAC + 2;
  localparam int SQ_W  = 2*IN_W - FRAC;
  localparam logic [ACC_W-1:0] c_out_max = ACC_W'((64'd1 << OUT_W) - 64'd1);

  sos_state_t       r_state;
  sos_state_t       w_next;
  logic [IN_W-1:0]  r_x, r_y, r_z;
  logic [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] r_sq;
  logic             r_sat;
  logic             r_valid;
  logic [IN_W-1:0]  w_op;
  logic [SQ_W-1:0]  w_sq;
  logic             w_accept;
  logic             w_over;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SQ_X;
      SQ_X:    w_next = SQ_Y;
      SQ_Y:    w_next = SQ_Z;
      SQ_Z:    w_next = SAT;
      SAT:     w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
  end

  assign w_accept = in_valid && in_ready;
  assign w_over   = (r_acc > c_out_max);

  always_comb begin
    w_op = r_z;
    case (r_state)
      SQ_X:    w_op = r_x;
      SQ_Y:    w_op = r_y;
      default: w_op = r_z;
    endcase
  end

  fx_square #(.IN_W(IN_W), .FRAC(FRAC)) u_fx_square (
    .i_v  (w_op),
    .o_sq (w_sq)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_acc   <= '0;
      r_sq    <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= x;
        r_y   <= y;
        r_z   <= z;
        r_acc <= '0;
      end
      if (r_state == SQ_X || r_state == SQ_Y || r_state == SQ_Z)
        r_acc <= r_acc + ACC_W'(w_sq);
      if (r_state == SAT) begin
        r_sq    <= w_over ? c_out_max[OUT_W-1:0] : r_acc[OUT_W-1:0];
        r_sat   <= w_over;
        r_valid <= 1'b1;
      end
      if (r_state == OUT && out_ready)
        r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sq    = r_sq;
  assign out_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_sum_of_squares.sv
// tb_sum_of_squares: directed self-checking bench for sum_of_squares.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_sum_of_squares;

  logic        clk;
  logic        rst_;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] x, y, z;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sq;
  logic        out_sat;

  int n_checks;
  int n_pass;

  sum_of_squares dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sq    (out_sq),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_term(input int v);
    int m;
    int p;
    m = (v < 0) ? -v : v;
    p = m * m;
`ifdef SUM_OF_SQUARES_ROUND_EN
    return (p + 8) / 16;
`else
    return p / 16;
`endif
  endfunction

  function automatic int model_sum(input int a, input int b, input int c);
    return model_term(a) + model_term(b) + model_term(c);
  endfunction

  // Offers a vector and returns #1 after the edge on which it was accepted.
  task automatic send(input int a, input int b, input int c, output bit acc_ok);
    acc_ok = 1'b0;
    in_valid = 1'b1;
    x = 12'(a);
    y = 12'(b);
    z = 12'(c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0; y = '0; z = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++;
    if (out_sq !== 12'd0) $display("FAIL reset_out_sq got=%0d want=0", out_sq); else n_pass++;
    n_checks++;
    if (out_sat !== 1'b0) $display("FAIL reset_out_sat got=%b want=0", out_sat); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single(input string name, input int a, input int b, input int c,
                             input int exp_sq, input bit exp_sat, input bit chk_lat);
    bit acc_ok;
    bit ok;
    int lat;
    send(a, b, c, acc_ok);
    n_checks++;
    if (!acc_ok) $display("FAIL %s_accept got=timeout want=accepted", name); else n_pass++;
    wait_out(lat, ok);
    if (chk_lat) begin
      n_checks++;
      if (!ok || lat != 4) $display("FAIL %s_latency got=%0d want=4", name, lat); else n_pass++;
    end
    n_checks++;
    if (!ok || out_sq !== 12'(exp_sq))
      $display("FAIL %s_sq got=%0d want=%0d", name, out_sq, exp_sq);
    else n_pass++;
    n_checks++;
    if (!ok || out_sat !== exp_sat)
      $display("FAIL %s_sat got=%b want=%b", name, out_sat, exp_sat);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    test_single("unit_x", 16, 0, 0, 16, 1'b0, 1'b1);
    test_single("two_each", 32, 32, 32, 192, 1'b0, 1'b1);
    test_single("min_neg", -2048, 0, 0, 4095, 1'b1, 1'b0);
    test_single("minus_lsb", -1, -1, -1, 0, 1'b0, 1'b0);
`ifdef SUM_OF_SQUARES_ROUND_EN
    test_single("round_three", 3, 0, 0, 1, 1'b0, 1'b0);
`else
    test_single("trunc_three", 3, 0, 0, 0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_backpressure();
    bit acc_ok;
    bit ok;
    bit stable;
    int lat;
    out_ready = 1'b0;
    send(48, 0, 0, acc_ok);
    wait_out(lat, ok);
    n_checks++;
    if (!ok || out_sq !== 12'd144) $display("FAIL bp_first_sq got=%0d want=144", out_sq); else n_pass++;
    in_valid = 1'b1;
    x = 12'd64; y = 12'd0; z = 12'd0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_sq !== 12'd144 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL bp_hold got=v%b/sq%0d/rdy%b want=v1/sq144/rdy0",
                          out_valid, out_sq, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_handshake got=v%b/rdy%b want=v0/rdy1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat, ok);
    n_checks++;
    if (!ok || lat != 4 || out_sq !== 12'd256)
      $display("FAIL bp_second got=sq%0d/lat%0d want=sq256/lat4", out_sq, lat);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    bit acc_ok;
    bit seen;
    send(48, 0, 0, acc_ok);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sq !== 12'd0 || out_sat !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midop_reset got=v%b/sq%0d/sat%b/rdy%b want=v0/sq0/sat0/rdy1",
               out_valid, out_sq, out_sat, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL midop_no_valid got=1 want=0"); else n_pass++;
    test_single("after_reset", 16, 0, 0, 16, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int va[4] = '{100, -2047, 1000, -7};
    int vb[4] = '{-200, 5, 1000, -9};
    int vc[4] = '{300, 7, 0, 11};
    bit acc_ok;
    bit ok;
    int lat;
    int s;
    int e;
    bit esat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = model_sum(va[i], vb[i], vc[i]);
      esat = (s > 4095);
      e = esat ? 4095 : s;
      send(va[i], vb[i], vc[i], acc_ok);
      wait_out(lat, ok);
      n_checks++;
      if (!ok || out_sq !== 12'(e) || out_sat !== esat)
        $display("FAIL b2b_%0d got=sq%0d/sat%b want=sq%0d/sat%b", i, out_sq, out_sat, e, esat);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_pulse_%0d got=1 want=0", i); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
